// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//
// Upstream feeder for the matrix-multiply / VGA display top. Elements arrive
// one word per beat on a valid/ready stream. The first E = MATRIX_N*MATRIX_M
// beats form operand A and the next E beats form operand B, both row-major.
// Once both operands are complete, read_ready pulses for one cycle. The
// loader then parks in WAIT_DONE until compute_done rises, and re-arms for
// the next frame. The operand buses only change on accepted beats, so they
// stay stable from read_ready until the next frame starts loading.
//
// Optional feature macro: LOADER_SLAST_EN
//   When defined, the s_last port exists and framing is checked against it.
//   A mismatch between s_last and the final-beat position pulses frame_err,
//   discards the frame position and restarts at A index 0. When the macro is
//   undefined, framing is purely by beat count and frame_err stays 0.
//
// Ports:
//   clk          in   system clock (only clock)
//   reset        in   asynchronous, active-low reset
//   s_valid      in   element valid
//   s_ready      out  loader can accept an element (decoded from state)
//   s_data       in   element value, WIDTH bits, unsigned
//   s_last       in   final beat of frame (LOADER_SLAST_EN only)
//   compute_done in   multiplier completion; acted on at its rising edge
//   matrix_a     out  operand A, flat, element (r,c) at (r*M+c)*WIDTH
//   matrix_b     out  operand B, flat, same layout
//   read_ready   out  one-cycle pulse, both operands complete
//   busy         out  high in PRESENT and WAIT_DONE
//   frame_err    out  one-cycle pulse on a framing violation
//   frame_count  out  number of frames presented, wraps at 256
// -----------------------------------------------------------------------------
module matrix_stream_loader #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [WIDTH-1:0]                   s_data,
`ifdef LOADER_SLAST_EN
  input  logic                               s_last,
`endif
  input  logic                               compute_done,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_a,
  output logic [MATRIX_N*MATRIX_M*WIDTH-1:0] matrix_b,
  output logic                               read_ready,
  output logic                               busy,
  output logic                               frame_err,
  output logic [7:0]                         frame_count
);

  localparam int E     = MATRIX_N * MATRIX_M;
  localparam int IDX_W = (E > 1) ? $clog2(E) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(E - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_PRESENT   = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       frame_count_q;
  logic             read_ready_q;
  logic             frame_err_q;
  logic             compute_done_q;

  logic beat_acc;
  logic idx_last;
  logic cd_rise;
  logic frame_viol;

  // s_ready depends only on registered state, never on s_valid.
  assign s_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy     = (state_q == S_PRESENT) || (state_q == S_WAIT_DONE);
  assign beat_acc = s_valid && s_ready;
  assign idx_last = (idx_q == LAST_IDX);
  assign cd_rise  = compute_done && !compute_done_q;

`ifdef LOADER_SLAST_EN
  // Only global beat 2E-1 (last index of B) may carry s_last, and it must.
  assign frame_viol = beat_acc && (s_last != ((state_q == S_LOAD_B) && idx_last));
`else
  assign frame_viol = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered pulse outputs and the frame counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      frame_count_q  <= 8'd0;
      read_ready_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      compute_done_q <= 1'b0;
    end else begin
      // Edge register runs in every state so edges seen outside WAIT_DONE
      // are consumed and a level already high on entry is not a new edge.
      compute_done_q <= compute_done;
      read_ready_q   <= 1'b0;
      frame_err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          state_q <= S_LOAD_A;
        end

        S_LOAD_A, S_LOAD_B: begin
          if (beat_acc) begin
            if (frame_viol) begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
              state_q     <= S_LOAD_A;
            end else if (idx_last) begin
              idx_q <= '0;
              if (state_q == S_LOAD_A) begin
                state_q <= S_LOAD_B;
              end else begin
                // Final B beat: present on the very next cycle.
                state_q       <= S_PRESENT;
                read_ready_q  <= 1'b1;
                frame_count_q <= frame_count_q + 8'd1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_PRESENT: begin
          state_q <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (cd_rise) begin
            state_q <= S_LOAD_A;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign read_ready  = read_ready_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

  // ---------------------------------------------------------------------------
  // Operand storage: one register pair per element slot. A slot is written
  // only by an accepted beat whose index matches it, which is what keeps the
  // buses stable outside the loading states.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < E; gi++) begin : g_elem
    logic [WIDTH-1:0] elem_a_q;
    logic [WIDTH-1:0] elem_b_q;
    logic             hit;

    assign hit = beat_acc && (idx_q == IDX_W'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        elem_a_q <= '0;
        elem_b_q <= '0;
      end else if (hit) begin
        if (state_q == S_LOAD_A) begin
          elem_a_q <= s_data;
        end else begin
          elem_b_q <= s_data;
        end
      end
    end

    assign matrix_a[gi*WIDTH +: WIDTH] = elem_a_q;
    assign matrix_b[gi*WIDTH +: WIDTH] = elem_b_q;
  end

endmodule
